// File: rtl/text_buffer_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : text_buffer_write_ctrl
//  Purpose  : Sequencer between the UART RX FIFO and the VGA text-mode
//             character buffer. Pops received bytes, handles printable
//             characters and CR/LF/BS, keeps a row/column cursor, clears a
//             line on every row advance and the whole screen after reset,
//             and echoes accepted bytes into the UART TX FIFO.
//  Ports    : clk, reset_n          - clock, async active-low reset
//             rx_empty, rx_data     - RX FIFO status / show-ahead head byte
//             rx_rd                 - RX FIFO pop pulse
//             tx_full               - TX FIFO full
//             tx_wr, tx_data        - TX FIFO push pulse / echoed byte
//             buf_we, buf_addr,
//             buf_wdata             - character buffer write port
//             cur_row, cur_col      - cursor position
//             busy                  - low only while idle
//  Revision : 1.0 - initial release
// ============================================================================
module text_buffer_write_ctrl #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_empty,
    input  logic [7:0]        rx_data,
    output logic              rx_rd,
    input  logic              tx_full,
    output logic              tx_wr,
    output logic [7:0]        tx_data,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic [4:0]        cur_row,
    output logic [6:0]        cur_col,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(ROWS * COLS - 1);
    localparam logic [6:0]        c_last_col  = 7'(COLS - 1);
    localparam logic [4:0]        c_last_row  = 5'(ROWS - 1);
    localparam logic [7:0]        c_space     = 8'h20;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_DECODE = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_ECHO   = 3'd4
    } state_t;

    state_t              r_state,     w_state_nxt;
    logic [7:0]          r_ch,        w_ch_nxt;
    logic [4:0]          r_row,       w_row_nxt;
    logic [6:0]          r_col,       w_col_nxt;
    logic [6:0]          r_clr_col,   w_clr_col_nxt;
    logic [ADDR_W-1:0]   r_init_addr, w_init_addr_nxt;
    logic                r_rx_rd,     w_rx_rd_nxt;
    logic                r_tx_wr,     w_tx_wr_nxt;
    logic [7:0]          r_tx_data,   w_tx_data_nxt;
    logic                r_buf_we,    w_buf_we_nxt;
    logic [ADDR_W-1:0]   r_buf_addr,  w_buf_addr_nxt;
    logic [7:0]          r_buf_wdata, w_buf_wdata_nxt;
    logic                r_busy;
    logic [4:0]          w_row_adv;

    function automatic logic [ADDR_W-1:0] f_addr(input logic [4:0] row,
                                                 input logic [6:0] col);
        f_addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    // The buffer does not scroll: advancing past the last row wraps to row 0.
    assign w_row_adv = (r_row == c_last_row) ? 5'd0 : r_row + 5'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_INIT;
            r_ch        <= 8'h00;
            r_row       <= 5'd0;
            r_col       <= 7'd0;
            r_clr_col   <= 7'd0;
            r_init_addr <= '0;
            r_rx_rd     <= 1'b0;
            r_tx_wr     <= 1'b0;
            r_tx_data   <= 8'h00;
            r_buf_we    <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_wdata <= 8'h00;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_ch        <= w_ch_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_clr_col   <= w_clr_col_nxt;
            r_init_addr <= w_init_addr_nxt;
            r_rx_rd     <= w_rx_rd_nxt;
            r_tx_wr     <= w_tx_wr_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_buf_we    <= w_buf_we_nxt;
            r_buf_addr  <= w_buf_addr_nxt;
            r_buf_wdata <= w_buf_wdata_nxt;
            // Follows the state one cycle late, so busy drops the cycle
            // after the last screen-clear write becomes visible.
            r_busy      <= (r_state != ST_IDLE);
        end
    end

    // Every output is computed one cycle ahead and registered, so the write
    // issued while in a state appears on the port in the following cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_ch_nxt        = r_ch;
        w_row_nxt       = r_row;
        w_col_nxt       = r_col;
        w_clr_col_nxt   = r_clr_col;
        w_init_addr_nxt = r_init_addr;
        w_rx_rd_nxt     = 1'b0;
        w_tx_wr_nxt     = 1'b0;
        w_tx_data_nxt   = r_tx_data;
        w_buf_we_nxt    = 1'b0;
        w_buf_addr_nxt  = r_buf_addr;
        w_buf_wdata_nxt = r_buf_wdata;

        case (r_state)
            ST_INIT: begin
                w_buf_we_nxt    = 1'b1;
                w_buf_addr_nxt  = r_init_addr;
                w_buf_wdata_nxt = c_space;
                if (r_init_addr == c_last_addr) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_init_addr_nxt = r_init_addr + 1'b1;
                end
            end

            ST_IDLE: begin
                if (!rx_empty) begin
                    w_rx_rd_nxt = 1'b1;
                    w_ch_nxt    = rx_data;
                    w_state_nxt = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (r_ch >= 8'h20 && r_ch <= 8'h7E) begin
                    w_buf_we_nxt    = 1'b1;
                    w_buf_addr_nxt  = f_addr(r_row, r_col);
                    w_buf_wdata_nxt = r_ch;
                    if (r_col < c_last_col) begin
                        w_col_nxt   = r_col + 7'd1;
                        w_state_nxt = ST_ECHO;
                    end else begin
                        // Character write occupies this cycle's output slot,
                        // so the line clear starts from column 0 in CLEAR.
                        w_col_nxt     = 7'd0;
                        w_row_nxt     = w_row_adv;
                        w_clr_col_nxt = 7'd0;
                        w_state_nxt   = ST_CLEAR;
                    end
                end else if (r_ch == 8'h0D) begin
                    w_col_nxt   = 7'd0;
                    w_state_nxt = ST_ECHO;
                end else if (r_ch == 8'h0A) begin
                    // The write slot is free here, so column 0 of the new
                    // row is cleared immediately and CLEAR resumes at 1.
                    w_row_nxt       = w_row_adv;
                    w_buf_we_nxt    = 1'b1;
                    w_buf_addr_nxt  = f_addr(w_row_adv, 7'd0);
                    w_buf_wdata_nxt = c_space;
                    w_clr_col_nxt   = 7'd1;
                    w_state_nxt     = ST_CLEAR;
                end else if (r_ch == 8'h08) begin
                    if (r_col != 7'd0) begin
                        w_col_nxt       = r_col - 7'd1;
                        w_buf_we_nxt    = 1'b1;
                        w_buf_addr_nxt  = f_addr(r_row, r_col - 7'd1);
                        w_buf_wdata_nxt = c_space;
                    end
                    w_state_nxt = ST_ECHO;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_CLEAR: begin
                w_buf_we_nxt    = 1'b1;
                w_buf_addr_nxt  = f_addr(r_row, r_clr_col);
                w_buf_wdata_nxt = c_space;
                if (r_clr_col == c_last_col) begin
                    w_state_nxt = ST_ECHO;
                end else begin
                    w_clr_col_nxt = r_clr_col + 7'd1;
                end
            end

            ST_ECHO: begin
                if (!tx_full) begin
                    w_tx_wr_nxt   = 1'b1;
                    w_tx_data_nxt = r_ch;
                    w_state_nxt   = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    assign rx_rd     = r_rx_rd;
    assign tx_wr     = r_tx_wr;
    assign tx_data   = r_tx_data;
    assign buf_we    = r_buf_we;
    assign buf_addr  = r_buf_addr;
    assign buf_wdata = r_buf_wdata;
    assign cur_row   = r_row;
    assign cur_col   = r_col;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_text_buffer_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_text_buffer_write_ctrl
//  Purpose  : Self-checking bench for text_buffer_write_ctrl. A small cursor
//             model queues the expected buffer writes and echoes as bytes
//             are offered; monitors pop and compare them as the DUT emits.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_text_buffer_write_ctrl;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int ADDR_W = 12;
    localparam int NCELL  = ROWS * COLS;

    logic              clk      = 1'b0;
    logic              reset_n  = 1'b0;
    logic              rx_empty = 1'b1;
    logic [7:0]        rx_data  = 8'h00;
    logic              tx_full  = 1'b0;
    logic              rx_rd;
    logic              tx_wr;
    logic [7:0]        tx_data;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_wdata;
    logic [4:0]        cur_row;
    logic [6:0]        cur_col;
    logic              busy;

    always #5 clk = ~clk;

    text_buffer_write_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_empty  (rx_empty),
        .rx_data   (rx_data),
        .rx_rd     (rx_rd),
        .tx_full   (tx_full),
        .tx_wr     (tx_wr),
        .tx_data   (tx_data),
        .buf_we    (buf_we),
        .buf_addr  (buf_addr),
        .buf_wdata (buf_wdata),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .busy      (busy)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    logic [7:0]  rx_q[$];
    logic [19:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    int          q_rx_t[$];
    int          q_we_t[$];
    int          q_tx_t[$];
    int          mr = 0;
    int          mc = 0;
    logic [19:0] mon_e;
    logic [7:0]  mon_t;

`define CHECK(TAG, OBS, EXP) begin \
        n_checks++; \
        assert ((OBS) === (EXP)) else begin \
            n_errors++; \
            $error("FAIL %s: observed=%0h expected=%0h", TAG, OBS, EXP); \
        end \
    end

    always @(posedge clk) cyc <= cyc + 1;

    // RX FIFO model: show-ahead head byte, popped on rx_rd.
    always @(negedge clk) begin
        if (rx_rd) begin
            if (rx_q.size() != 0) void'(rx_q.pop_front());
            q_rx_t.push_back(cyc);
        end
        rx_empty = (rx_q.size() == 0);
        rx_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (buf_we) begin
            q_we_t.push_back(cyc);
            n_checks++;
            assert (exp_wr.size() != 0) else begin
                n_errors++;
                $error("FAIL unexpected_write: observed addr=%0d data=%0h expected=no write",
                       buf_addr, buf_wdata);
            end
            if (exp_wr.size() != 0) begin
                mon_e = exp_wr.pop_front();
                `CHECK("buf_write{addr,data}", {buf_addr, buf_wdata}, mon_e)
            end
        end
        if (tx_wr) begin
            q_tx_t.push_back(cyc);
            n_checks++;
            assert (exp_tx.size() != 0) else begin
                n_errors++;
                $error("FAIL unexpected_echo: observed=%0h expected=no echo", tx_data);
            end
            if (exp_tx.size() != 0) begin
                mon_t = exp_tx.pop_front();
                `CHECK("echo_data", tx_data, mon_t)
            end
        end
        if (rx_rd) `CHECK("rx_rd_with_tx_wr", tx_wr, 1'b0)
    end

    task automatic push_wr(input int a, input logic [7:0] d);
        exp_wr.push_back({12'(a), d});
    endtask

    task automatic push_clear_row();
        for (int c = 0; c < COLS; c++) push_wr(mr * COLS + c, 8'h20);
    endtask

    task automatic adv_row();
        mr = (mr == ROWS - 1) ? 0 : mr + 1;
    endtask

    // Cursor model: queues expected writes/echo, then offers the byte.
    task automatic send(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_wr(mr * COLS + mc, b);
            if (mc < COLS - 1) mc++;
            else begin
                mc = 0;
                adv_row();
                push_clear_row();
            end
            exp_tx.push_back(b);
        end else if (b == 8'h0D) begin
            mc = 0;
            exp_tx.push_back(b);
        end else if (b == 8'h0A) begin
            adv_row();
            push_clear_row();
            exp_tx.push_back(b);
        end else if (b == 8'h08) begin
            if (mc > 0) begin
                mc--;
                push_wr(mr * COLS + mc, 8'h20);
            end
            exp_tx.push_back(b);
        end
        rx_q.push_back(b);
    endtask

    task automatic push_init();
        for (int i = 0; i < NCELL; i++) push_wr(i, 8'h20);
    endtask

    task automatic clear_times();
        q_rx_t.delete();
        q_we_t.delete();
        q_tx_t.delete();
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((rx_q.size() != 0 || exp_wr.size() != 0 || exp_tx.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        `CHECK("drain_within_budget", (n < budget), 1'b1)
        repeat (3) @(negedge clk);
    endtask

    task automatic check_cursor(input string tag, input int r, input int c);
        `CHECK({tag, "_row"}, cur_row, 5'(r))
        `CHECK({tag, "_col"}, cur_col, 7'(c))
    endtask

    initial begin
        int r0;
        int viol;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        `CHECK("reset_busy", busy, 1'b1)
        `CHECK("reset_buf_we", buf_we, 1'b0)
        `CHECK("reset_rx_rd", rx_rd, 1'b0)
        `CHECK("reset_tx_wr", tx_wr, 1'b0)
        `CHECK("reset_buf_addr", buf_addr, 12'd0)
        check_cursor("reset", 0, 0);

        // ---------------- power-up screen clear ----------------
        push_init();
        clear_times();
        r0 = cyc;
        reset_n = 1'b1;
        wait_drain(3000);
        `CHECK("init_write_count", q_we_t.size(), NCELL)
        `CHECK("init_first_cycle", q_we_t[0] - r0, 1)
        `CHECK("init_last_cycle", q_we_t[NCELL-1] - r0, NCELL)
        `CHECK("idle_busy", busy, 1'b0)
        check_cursor("after_init", 0, 0);

        // ---------------- "Hi" with latency/throughput ----------------
        clear_times();
        send(8'h48);
        send(8'h69);
        wait_drain(100);
        `CHECK("hi_write_latency", q_we_t[0] - q_rx_t[0], 1)
        `CHECK("hi_echo_latency", q_tx_t[0] - q_rx_t[0], 2)
        `CHECK("hi_rx_spacing", q_rx_t[1] - q_rx_t[0], 3)
        check_cursor("hi", 0, 2);

        // ---------------- CR LF from (0,12) ----------------
        for (int i = 0; i < 10; i++) send(8'h78);
        wait_drain(200);
        check_cursor("col12", 0, 12);
        clear_times();
        send(8'h0D);
        send(8'h0A);
        wait_drain(300);
        `CHECK("lf_clear_count", q_we_t.size(), COLS)
        `CHECK("lf_clear_first", q_we_t[0] - q_rx_t[1], 1)
        `CHECK("lf_clear_last", q_we_t[COLS-1] - q_rx_t[1], COLS)
        `CHECK("lf_echo_cycle", q_tx_t[1] - q_rx_t[1], COLS + 1)
        check_cursor("crlf", 1, 0);

        // ---------------- walk to (29,5), LF wraps to row 0 ----------------
        for (int i = 0; i < 28; i++) send(8'h0A);
        wait_drain(4000);
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
        wait_drain(100);
        check_cursor("row29", 29, 5);
        send(8'h0A);
        wait_drain(300);
        check_cursor("lf_wrap", 0, 5);

        // ---------------- backspace, BS at col 0, discarded BEL -------------
        send(8'h08);
        wait_drain(100);
        check_cursor("bs", 0, 4);
        send(8'h0D);
        send(8'h08);
        send(8'h07);
        wait_drain(100);
        check_cursor("bs_col0_bel", 0, 0);

        // ---------------- 80 x 'A' wraps the line ----------------
        clear_times();
        for (int i = 0; i < COLS; i++) send(8'h41);
        wait_drain(800);
        `CHECK("wrap_write_count", q_we_t.size(), 2 * COLS)
        `CHECK("wrap_clear_first", q_we_t[COLS] - q_rx_t[COLS-1], 2)
        `CHECK("wrap_clear_last", q_we_t[2*COLS-1] - q_rx_t[COLS-1], COLS + 1)
        `CHECK("wrap_echo_cycle", q_tx_t[COLS-1] - q_rx_t[COLS-1], COLS + 2)
        check_cursor("wrap", 1, 0);

        // ---------------- TX backpressure ----------------
        tx_full = 1'b1;
        send(8'h5A);
        send(8'h51);
        send(8'h52);
        repeat (6) @(negedge clk);
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_wr || rx_rd) viol++;
        end
        `CHECK("stall_no_tx_or_rx", viol, 0)
        tx_full = 1'b0;
        @(negedge clk);
        `CHECK("echo_after_full_release", tx_wr, 1'b1)
        wait_drain(100);
        check_cursor("after_stall", 1, 3);

        // ---------------- reset mid-CLEAR ----------------
        send(8'h0A);
        repeat (20) @(negedge clk);
        `CHECK("pre_reset_row", cur_row, 5'd2)
        #2;
        reset_n = 1'b0;
        #1;
        `CHECK("midreset_buf_we", buf_we, 1'b0)
        `CHECK("midreset_buf_addr", buf_addr, 12'd0)
        `CHECK("midreset_buf_wdata", buf_wdata, 8'h00)
        `CHECK("midreset_tx_data", tx_data, 8'h00)
        `CHECK("midreset_busy", busy, 1'b1)
        check_cursor("midreset", 0, 0);
        exp_wr.delete();
        exp_tx.delete();
        rx_q.delete();
        mr = 0;
        mc = 0;
        repeat (3) @(negedge clk);
        // A byte waiting during INIT must not be popped until INIT ends.
        push_init();
        send(8'h4B);
        clear_times();
        r0 = cyc;
        reset_n = 1'b1;
        wait_drain(3000);
        `CHECK("reinit_write_count", q_we_t.size(), NCELL + 1)
        `CHECK("reinit_first_cycle", q_we_t[0] - r0, 1)
        `CHECK("reinit_no_pop_during_init", (q_rx_t[0] >= q_we_t[NCELL-1]), 1'b1)
        `CHECK("reinit_busy", busy, 1'b0)
        check_cursor("reinit", 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/text_buffer_write_ctrl.md
# text_buffer_write_ctrl

Sequencer between the UART receive FIFO and the text-mode character buffer of the VGA text display. It pops received bytes, interprets printable characters and the CR/LF/BS controls, and keeps a row/column cursor. It owns the buffer write port, issuing character writes, line clears on row advance, and a full-screen clear after reset. Accepted bytes are echoed into the UART transmit FIFO.

## Interface
- COLS, 80, characters per row
- ROWS, 30, rows per screen
- ADDR_W, 12, buffer address width; requires ROWS*COLS <= 2^ADDR_W

- clk  in  1  system clock (100 MHz)
- reset_n  in  1  asynchronous, active-low reset
- rx_empty  in  1  RX FIFO empty
- rx_data  in  8  RX FIFO head byte, show-ahead (valid while rx_empty=0)
- rx_rd  out  1  RX FIFO pop, one-cycle pulse
- tx_full  in  1  TX FIFO full
- tx_wr  out  1  TX FIFO push, one-cycle pulse
- tx_data  out  8  echoed byte
- buf_we  out  1  character buffer write enable
- buf_addr  out  ADDR_W  buffer address, row*COLS+col
- buf_wdata  out  8  buffer write data
- cur_row  out  5  cursor row, 0..ROWS-1
- cur_col  out  7  cursor column, 0..COLS-1
- busy  out  1  high in every state except IDLE

## Operation
- All outputs are registered. While reset_n=0: rx_rd, tx_wr, buf_we = 0; tx_data, buf_addr, buf_wdata = 0; cursor = (0,0); busy = 1; state = INIT.
- INIT:
  - Writes 0x20 to addresses 0..ROWS*COLS-1, one per cycle.
  - Never asserts rx_rd.
  - Goes to IDLE after the last address.
- IDLE: if rx_empty=0, pulse rx_rd, latch rx_data into ch, go to DECODE.
- DECODE, by value of ch:
  - 0x20..0x7E: write ch at the cursor. If col < COLS-1, increment col and go to ECHO. Otherwise set col=0, advance row, go to CLEAR.
  - 0x0D (CR): col=0, go to ECHO.
  - 0x0A (LF): advance row, leave col unchanged, go to CLEAR.
  - 0x08 (BS): if col > 0, decrement col, write 0x20 at the new position, go to ECHO. If col = 0, no write; go to ECHO.
  - Any other value: discarded, no echo, back to IDLE.
- Row advance: row = (row == ROWS-1) ? 0 : row+1. The buffer does not scroll; it wraps to row 0.
- CLEAR: writes 0x20 to columns 0..COLS-1 of the new cursor row on COLS consecutive cycles, then goes to ECHO. Cursor outputs already show the new position during CLEAR.
- ECHO: hold while tx_full=1. Otherwise pulse tx_wr with tx_data=ch and return to IDLE.
- No new byte is popped until the previous one has been echoed or discarded. Backpressure on the RX side comes only from tx_full and CLEAR duration.
- Reset mid-operation: all activity aborts immediately and the block re-enters INIT. A popped byte that was not yet written or echoed is lost.

## Timing
- Let C be the cycle in which rx_rd is high.
- Printable or BS write: buf_we high in cycle C+1 only, with buf_addr and buf_wdata valid in the same cycle.
- Echo: tx_wr high at C+2 if tx_full=0. Each cycle tx_full=1 adds one cycle.
- Next rx_rd: earliest C+3. Best-case sustained throughput is 1 byte per 3 cycles.
- Row advance (wrap or LF): clear writes occupy C+1..C+COLS for LF, or C+2..C+COLS+1 after a wrapping printable. The echo follows at the next cycle.
- INIT: buf_we high for ROWS*COLS consecutive cycles, starting the first clock edge after reset_n rises. busy falls the cycle after the last write.
- buf_we is never high in two different requesters' states at once. Only one of INIT, DECODE-write or CLEAR drives the port in any cycle.
- tx_wr and rx_rd are never high in the same cycle.

## Test plan
- Reset release: buf_we high for exactly 2400 cycles, addresses 0..2399 ascending, data 0x20. Then busy=0 and cursor (0,0).
- From (0,0), send "Hi": writes 0x48 to address 0 and 0x69 to address 1; echoes 0x48 then 0x69. Cursor ends at (0,2).
- At (0,12), send 0x0D, 0x0A: no character writes; addresses 80..159 cleared to 0x20. Cursor ends at (1,0); echoes 0x0D, 0x0A.
- Send 80 x 'A' from (0,0): writes to addresses 0..79, then 80 clears of addresses 80..159. Cursor ends at (1,0); 80 echoes.
- Cursor at (29,5), send 0x0A: cursor moves to (0,5) and addresses 0..79 are cleared. Then send 0x08: 0x20 written at address 4 and cursor at (0,4). Send 0x08 at col 0: no write. Send 0x07: no write, no echo, cursor unchanged.
- Hold tx_full=1 for 100 cycles while in ECHO, with bytes waiting in the RX FIFO: tx_wr and rx_rd stay low throughout. One tx_wr pulse follows tx_full falling. Assert reset_n=0 mid-CLEAR: outputs go to their reset values immediately and INIT restarts on release.
